// File: rtl/bs_addsub_mc.sv
// Multi-lane, word-framed, LSB-first bit-serial adder/subtractor.
// Lanes share sow/valid framing; each keeps its own carry and add/sub mode.
module bs_addsub_mc #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          sow,
  input  logic [CH-1:0] sub,
  input  logic [CH-1:0] x,
  input  logic [CH-1:0] y,
  output logic [CH-1:0] z,
  output logic          z_valid,
  output logic          z_sow,
  output logic          z_eow,
  output logic [CH-1:0] cout,
  output logic [CH-1:0] ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CH-1:0] carry_q, carry_d;
  logic [CH-1:0] mode_q, mode_d;
  logic [CH-1:0] z_q, z_d;
  logic          z_valid_q, z_valid_d;
  logic          z_sow_q, z_sow_d;
  logic          z_eow_q, z_eow_d;
  logic [CH-1:0] cout_q, cout_d;
  logic [CH-1:0] ovf_q, ovf_d;

  logic          start, run, msb;
  logic [CH-1:0] mode_eff, cin_v, yy_v, s_v, cn_v;

  always_comb begin
    start = in_valid & sow;
    run   = in_valid & ~sow & (state_q == RUN);
    msb   = run & (cnt_q == LAST);

    // On the sow beat the lane's own sub input replaces both mode and carry.
    mode_eff = start ? sub : mode_q;
    cin_v    = start ? sub : carry_q;
    yy_v     = y ^ mode_eff;
    s_v      = x ^ yy_v ^ cin_v;
    cn_v     = (x & yy_v) | (x & cin_v) | (yy_v & cin_v);

    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    mode_d    = mode_q;
    z_d       = z_q;
    z_valid_d = 1'b0;
    z_sow_d   = 1'b0;
    z_eow_d   = 1'b0;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    if (start | run) begin
      carry_d   = cn_v;
      z_d       = s_v;
      z_valid_d = 1'b1;
      z_sow_d   = start;
      z_eow_d   = msb;
    end

    if (start) begin
      mode_d  = sub;
      cnt_d   = CW'(1);
      state_d = RUN;
    end else if (run) begin
      if (msb) begin
        cnt_d   = '0;
        state_d = IDLE;
        cout_d  = cn_v;
        ovf_d   = cin_v ^ cn_v;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= '0;
      mode_q    <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      z_sow_q   <= 1'b0;
      z_eow_q   <= 1'b0;
      cout_q    <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      mode_q    <= mode_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      z_sow_q   <= z_sow_d;
      z_eow_q   <= z_eow_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign z_sow   = z_sow_q;
  assign z_eow   = z_eow_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bs_addsub_mc.sv
// Directed scoreboard bench for bs_addsub_mc, WIDTH=8, CH=2.
// Each driven cycle pushes its expected output, checked one cycle later.
module tb_bs_addsub_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       sow;
  logic [1:0] sub;
  logic [1:0] x;
  logic [1:0] y;
  logic [1:0] z;
  logic       z_valid;
  logic       z_sow;
  logic       z_eow;
  logic [1:0] cout;
  logic [1:0] ovf;

  int vectors = 0;
  int errs    = 0;

  typedef struct packed {
    logic       all0;
    logic       v;
    logic       sw;
    logic       ew;
    logic [1:0] z;
    logic [1:0] co;
    logic [1:0] ov;
  } exp_t;

  exp_t sb[$];

  bs_addsub_mc #(.WIDTH(8), .CH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sow(sow),
    .sub(sub), .x(x), .y(y), .z(z), .z_valid(z_valid),
    .z_sow(z_sow), .z_eow(z_eow), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("z_valid", {7'b0, z_valid}, {7'b0, e.v});
      if (e.all0) begin
        chk("rst_z", {6'b0, z}, 8'h00);
        chk("rst_sow", {7'b0, z_sow}, 8'h00);
        chk("rst_eow", {7'b0, z_eow}, 8'h00);
        chk("rst_cout", {6'b0, cout}, 8'h00);
        chk("rst_ovf", {6'b0, ovf}, 8'h00);
      end else begin
        chk("z_sow", {7'b0, z_sow}, {7'b0, e.sw});
        chk("z_eow", {7'b0, z_eow}, {7'b0, e.ew});
        if (e.v) chk("z", {6'b0, z}, {6'b0, e.z});
        if (e.ew) begin
          chk("cout", {6'b0, cout}, {6'b0, e.co});
          chk("ovf", {6'b0, ovf}, {6'b0, e.ov});
        end
      end
    end
  end

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                input logic s, output logic [7:0] r,
                                output logic co, output logic ov);
    logic [8:0] t;
    if (s) begin
      t  = {1'b0, a} - {1'b0, b};
      r  = t[7:0];
      co = (a >= b);
      ov = (a[7] != b[7]) && (r[7] != a[7]);
    end else begin
      t  = {1'b0, a} + {1'b0, b};
      r  = t[7:0];
      co = t[8];
      ov = (a[7] == b[7]) && (r[7] != a[7]);
    end
  endfunction

  task automatic drive(input logic r, input logic v, input logic sw,
                       input logic [1:0] xx, input logic [1:0] yy,
                       input logic [1:0] ss, input exp_t e);
    @(negedge clk);
    #1;
    rst      = r;
    in_valid = v;
    sow      = sw;
    x        = xx;
    y        = yy;
    sub      = ss;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'($urandom), 2'($urandom), 2'($urandom),
            2'($urandom), e);
  endtask

  task automatic drop(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b1, 1'b0, 2'($urandom), 2'($urandom),
            2'($urandom), e);
  endtask

  task automatic send_word(input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input logic [1:0] s, input int nb,
                           input int stall_at, input int stall_n);
    logic [7:0] r0, r1;
    logic       c0, c1, o0, o1;
    exp_t       e;
    model(a0, b0, s[0], r0, c0, o0);
    model(a1, b1, s[1], r1, c1, o1);
    for (int k = 0; k < nb; k++) begin
      e      = '0;
      e.v    = 1'b1;
      e.sw   = (k == 0);
      e.ew   = (k == 7);
      e.z    = {r1[k], r0[k]};
      e.co   = {c1, c0};
      e.ov   = {o1, o0};
      drive(1'b0, 1'b1, (k == 0), {a1[k], a0[k]}, {b1[k], b0[k]},
            (k == 0) ? s : 2'($urandom), e);
      if (k == stall_at) idle(stall_n);
    end
  endtask

  initial begin
    exp_t e;
    rst      = 1'b1;
    in_valid = 1'b0;
    sow      = 1'b0;
    sub      = 2'b00;
    x        = 2'b00;
    y        = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_z_valid", {7'b0, z_valid}, 8'h00);
    chk("reset_z", {6'b0, z}, 8'h00);
    chk("reset_cout", {6'b0, cout}, 8'h00);
    #1 rst = 1'b0;

    // add: 05+03 and 7F+01
    send_word(8'h05, 8'h03, 8'h7F, 8'h01, 2'b00, 8, -1, 0);
    idle(2);
    // subtract, back-to-back
    send_word(8'h10, 8'h01, 8'h00, 8'h01, 2'b11, 8, -1, 0);
    send_word(8'h80, 8'h01, 8'h33, 8'h44, 2'b01, 8, -1, 0);
    idle(1);
    // stall after bit 3
    send_word(8'h5A, 8'h25, 8'hC8, 8'h9C, 2'b00, 8, 3, 3);
    // abort at bit 5, then fresh word
    send_word(8'hFF, 8'h01, 8'hAA, 8'h55, 2'b10, 5, -1, 0);
    send_word(8'h01, 8'h01, 8'h01, 8'h01, 2'b00, 8, -1, 0);
    // dropped beats after MSB, then back-to-back words
    drop(3);
    send_word(8'h12, 8'h34, 8'h80, 8'h80, 2'b00, 8, -1, 0);
    send_word(8'hFF, 8'h01, 8'h7F, 8'hFF, 2'b10, 8, -1, 0);
    // reset mid subtract at bit 4
    send_word(8'h40, 8'h11, 8'h22, 8'h33, 2'b11, 4, -1, 0);
    e      = '0;
    e.all0 = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b11, 2'b11, 2'b11, e);
    send_word(8'h03, 8'h04, 8'h03, 8'h04, 2'b00, 8, -1, 0);
    idle(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("drain", 8'(sb.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
